// File: rtl/mem_pkg.sv
// mem_pkg: shared state type and default sizing for the cache miss controller
package mem_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT = 255;
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} cache_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter import mem_pkg::*; #(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (en && !(&count)) count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: miss handler sequencing write-back and refill, stalling the CPU until the line is ready
module cache_ctrl import mem_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic                  hit,
    input  logic                  dirty,
    input  logic [DATA_WIDTH-1:0] victim_addr,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  refill_en,
    output logic [DATA_WIDTH-1:0] miss_count,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    cache_state_t state;
    logic [DATA_WIDTH-1:0] req_addr, wb_addr;
    logic [CW-1:0] wait_cnt;
    logic miss, busy, timed_out;
    assign miss = (rd_en | wr_en) & ~hit;
    assign busy = state == WRITEBACK || state == REFILL;
    // the wait that would bring the counter to TIMEOUT ends the access
    assign timed_out = busy && !mem_ready && wait_cnt == CW'(TIMEOUT - 1);
    always_comb begin
        stall = state == IDLE ? miss : 1'b1;
        mem_req = busy;
        mem_we = state == WRITEBACK;
        mem_addr = state == WRITEBACK ? wb_addr : req_addr;
        refill_en = state == REFILL && mem_ready;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_addr <= '0;
            wb_addr <= '0;
            wait_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                IDLE: if (miss) begin
                    state <= dirty ? WRITEBACK : REFILL;
                    req_addr <= addr & ~DATA_WIDTH'(3);
                    wb_addr <= victim_addr;
                end
                WRITEBACK, REFILL: begin
                    if (mem_ready) state <= state == WRITEBACK ? REFILL : DONE;
                    else if (timed_out) begin
                        state <= IDLE;
                        timeout_err <= 1'b1;
                    end else wait_cnt <= wait_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
    sat_counter #(.WIDTH(DATA_WIDTH)) u_miss (
        .clk(clk),
        .rst(rst),
        .en(state == IDLE && miss),
        .count(miss_count)
    );
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench; a 3-bit twin instance shares the stimulus to exercise counter saturation
module tb_cache_ctrl;
    localparam int TO = 4;
    logic clk = 0, rst = 1, rd_en = 0, wr_en = 0, hit = 0, dirty = 0, mem_ready = 0;
    logic [31:0] addr = 0, victim_addr = 0;
    logic stall, mem_req, mem_we, refill_en, timeout_err;
    logic [31:0] mem_addr, miss_count;
    logic s_stall, s_mem_req, s_mem_we, s_refill_en, s_timeout_err;
    logic [2:0] s_mem_addr, s_miss_count;
    int checks = 0, errors = 0, nmiss = 0, nrefill = 0, exp_refill = 0;
    logic exp_err = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) if (refill_en) nrefill++;

    cache_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .hit(hit),
        .dirty(dirty), .victim_addr(victim_addr), .mem_ready(mem_ready), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .refill_en(refill_en),
        .miss_count(miss_count), .timeout_err(timeout_err)
    );
    cache_ctrl #(.DATA_WIDTH(3), .TIMEOUT(TO)) dut_small (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr[2:0]), .hit(hit),
        .dirty(dirty), .victim_addr(victim_addr[2:0]), .mem_ready(mem_ready), .stall(s_stall),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .refill_en(s_refill_en),
        .miss_count(s_miss_count), .timeout_err(s_timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] v, input logic rd, input logic wr,
                           input logic d, input int wbw, input int rfw);
        int cyc, ph, exp_cyc;
        logic to;
        logic [32:0] e;
        to = 0;
        exp_cyc = 0;
        e = '0;
        if (d) begin
            if (wbw < TO) exp_cyc += wbw + 1;
            else begin exp_cyc += TO; to = 1; end
        end
        if (!to) begin
            if (rfw < TO) exp_cyc += rfw + 2;
            else begin exp_cyc += TO; to = 1; end
        end
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; victim_addr = v; hit = 0; dirty = d; mem_ready = 0;
        #1 check("stall_idle_miss", stall, 1);
        check("req_idle", mem_req, 0);
        if (d) sb.push_back({1'b1, v});
        sb.push_back({1'b0, a & ~32'h3});
        nmiss++;
        @(negedge clk);
        hit = 1; dirty = 0; cyc = 0; ph = 0;
        while (stall && cyc < 2000) begin
            if (mem_req) begin
                if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
                else begin
                    e = sb[0];
                    check("mem_we", mem_we, e[32]);
                    check("mem_addr", mem_addr, e[31:0]);
                end
                mem_ready = ph >= (e[32] ? wbw : rfw);
                #1 check("refill_en", refill_en, mem_ready && !e[32]);
                if (mem_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    ph = 0;
                end else ph++;
            end else check("done_refill_en", refill_en, 0);
            @(negedge clk);
            mem_ready = 0;
            cyc++;
        end
        rd_en = 0; wr_en = 0; hit = 0;
        check("stall_cycles", cyc, exp_cyc);
        if (to) begin
            sb.delete();
            exp_err = 1;
        end else exp_refill++;
        check("sb_drained", sb.size(), 0);
        check("miss_count", miss_count, nmiss);
        check("miss_count_sat", s_miss_count, nmiss > 7 ? 7 : nmiss);
        check("timeout_err", timeout_err, exp_err);
        check("refill_pulses", nrefill, exp_refill);
    endtask

    initial begin
        #1;
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        do_miss(32'h0000_1006, 32'h0, 1, 0, 0, 0, 3);
        do_miss(32'h0000_3010, 32'h0000_2000, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_en = 1; hit = 1; addr = $urandom;
            #1 check("hit_stall", stall, 0);
            check("hit_mem_req", mem_req, 0);
        end
        @(negedge clk);
        rd_en = 0; hit = 0;
        check("hit_miss_count", miss_count, nmiss);
        do_miss(32'h0000_4003, 32'h0000_5000, 1, 1, 0, 1, 2);
        for (int i = 0; i < 6; i++)
            do_miss($urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        do_miss(32'h0000_6000, 32'h0, 1, 0, 0, 0, 50);
        do_miss(32'h0000_7000, 32'h0000_8000, 0, 1, 1, 100, 0);
        do_miss(32'h0000_7008, 32'h0000_8000, 1, 0, 1, 1, 1);
        @(negedge clk);
        rd_en = 1; hit = 0; dirty = 0; addr = 32'h0000_9004;
        @(negedge clk);
        hit = 1;
        check("pre_rst_mem_req", mem_req, 1);
        #2 rst = 1; mem_ready = 1;
        #1 check("arst_stall", stall, 0);
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_refill_en", refill_en, 0);
        check("arst_miss_count", miss_count, 0);
        check("arst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst = 0; rd_en = 0; hit = 0; mem_ready = 0;
        sb.delete();
        nmiss = 0;
        exp_err = 0;
        check("arst_no_refill", nrefill, exp_refill);
        do_miss(32'h0000_A00E, 32'h0, 1, 0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
